// File: rtl/fpga_rst_pkg.sv
// Shared types and parameter defaults for the FPGA reset sequencer.
package fpga_rst_pkg;

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        WAIT_CALIB = 2'd1,
        DEV_RUN    = 2'd2,
        CPU_RUN    = 2'd3
    } rst_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES      = 50000;
    localparam int unsigned DEF_RST_HOLD_CYCLES      = 256;
    localparam int unsigned DEF_START_GAP_CYCLES     = 16;
    localparam bit          DEF_START_ON_BUTTON      = 1'b1;
    localparam int unsigned DEF_CALIB_TIMEOUT_CYCLES = 50_000_000;

endpackage

// File: rtl/rst_debounce.sv
// Button synchronizer and debouncer producing single-cycle press/release pulses.
module rst_debounce
    import fpga_rst_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             btn_meta;
    logic             btn_sync;
    logic             btn_db;
    logic [CNT_W-1:0] cnt;

    // Synchronizer resets to the released level so reset itself is never seen as a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
        end else begin
            btn_meta <= btn_n_i;
            btn_sync <= btn_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            btn_db      <= 1'b1;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (btn_sync == btn_db) begin
                cnt <= '0;
            end else if (32'(cnt) + 32'd1 >= DEBOUNCE_CYCLES) begin
                cnt         <= '0;
                btn_db      <= btn_sync;
                btn_press   <= btn_db;
                btn_release <= ~btn_db;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fpga_rst_sequencer.sv
// Orders device, CPU and PHY reset release behind DDR calibration and the board button.
module fpga_rst_sequencer
    import fpga_rst_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned RST_HOLD_CYCLES      = DEF_RST_HOLD_CYCLES,
    parameter int unsigned START_GAP_CYCLES     = DEF_START_GAP_CYCLES,
    parameter bit          START_ON_BUTTON      = DEF_START_ON_BUTTON,
    parameter int unsigned CALIB_TIMEOUT_CYCLES = DEF_CALIB_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n_i,
    input  logic       calib_done_i,
    output logic       dev_rstn,
    output logic       cpu_rstn,
    output logic       phy_rst_b,
    output logic [1:0] state_o,
    output logic       calib_timeout_o
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam int unsigned GAP_W  = $clog2(START_GAP_CYCLES + 1);
    localparam int unsigned TO_W   = $clog2(CALIB_TIMEOUT_CYCLES + 1);

    rst_state_e        state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic [GAP_W-1:0]  gap_cnt, gap_next;
    logic [TO_W-1:0]   to_cnt, to_next;
    logic              timeout_next;
    logic              dev_next, cpu_next;
    logic              calib_meta, calib_sync;
    logic              btn_press, btn_release;

    rst_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .btn_n_i    (btn_n_i),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            calib_meta <= 1'b0;
            calib_sync <= 1'b0;
        end else begin
            calib_meta <= calib_done_i;
            calib_sync <= calib_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= HOLD;
            hold_cnt        <= '0;
            gap_cnt         <= '0;
            to_cnt          <= '0;
            calib_timeout_o <= 1'b0;
            dev_rstn        <= 1'b0;
            cpu_rstn        <= 1'b0;
        end else begin
            state           <= state_next;
            hold_cnt        <= hold_next;
            gap_cnt         <= gap_next;
            to_cnt          <= to_next;
            calib_timeout_o <= timeout_next;
            dev_rstn        <= dev_next;
            cpu_rstn        <= cpu_next;
        end
    end

    // Counters clear whenever their state is not active, so each visit starts fresh
    always_comb begin
        state_next   = state;
        hold_next    = '0;
        gap_next     = '0;
        to_next      = '0;
        timeout_next = calib_timeout_o;
        unique case (state)
            HOLD: begin
                if (32'(hold_cnt) + 32'd1 >= RST_HOLD_CYCLES) begin
                    state_next = WAIT_CALIB;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            WAIT_CALIB: begin
                if (to_cnt != TO_W'(CALIB_TIMEOUT_CYCLES)) begin
                    to_next = to_cnt + TO_W'(1);
                end else begin
                    to_next = to_cnt;
                end
                if (to_next == TO_W'(CALIB_TIMEOUT_CYCLES)) begin
                    timeout_next = 1'b1;
                end
                if (calib_sync) begin
                    state_next = DEV_RUN;
                end
            end
            DEV_RUN: begin
                if (!calib_sync) begin
                    state_next = WAIT_CALIB;
                end else if (START_ON_BUTTON) begin
                    if (btn_release) begin
                        state_next = CPU_RUN;
                    end
                end else if (32'(gap_cnt) + 32'd1 >= START_GAP_CYCLES) begin
                    state_next = CPU_RUN;
                end else begin
                    gap_next = gap_cnt + GAP_W'(1);
                end
            end
            CPU_RUN: begin
                if (!calib_sync) begin
                    state_next = WAIT_CALIB;
                end else if (btn_press) begin
                    state_next = DEV_RUN;
                end
            end
        endcase
        dev_next = (state_next == DEV_RUN) || (state_next == CPU_RUN);
        cpu_next = (state_next == CPU_RUN);
    end

    assign phy_rst_b = cpu_rstn;
    assign state_o   = state;

endmodule
